decoder_pipe: RTL
=================

Name: decoder_pipe

Overview:
- Parametrised, registered successor to the combinational 2-to-4 decoder.
- Decodes an IN_W-bit index into a 2^IN_W-bit code, either one-hot or thermometer, selected per transfer.
- Uses valid/ready handshakes on both sides, with a 2-entry output buffer so full throughput survives a registered in_ready.
- Sits between an index producer (register-file select, bank select) and consumers that may stall.

Parameters:
- IN_W, 2, index width; output width OUT_W = 2^IN_W (local, derived).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a transfer.
- in_ready  output  1  block can accept; registered.
- in_idx  input  IN_W  index to decode.
- in_mode  input  1  0 = one-hot, 1 = thermometer.
- in_en  input  1  0 = emit all-zero code (disabled decode).
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts.
- out_code  output  OUT_W  decoded code.
- xfer_cnt  output  CNT_W  count of completed output transfers.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out_valid=0, out_code=0, xfer_cnt=0, in_ready=1; skid entry cleared.
  - State is EMPTY, held until rst_n deasserts.
- Accept occurs when in_valid & in_ready. Drain occurs when out_valid & out_ready.
- Decode is combinational on the input side; the result is captured into a register. Effective code:
  - in_en=0: all zeros, regardless of mode and index.
  - mode 0: bit in_idx set, all others 0. Example IN_W=2, idx=2 gives 4'b0100.
  - mode 1: bits 0..in_idx set. Example IN_W=2, idx=2 gives 4'b0111; idx=0 gives 4'b0001; idx=3 gives all ones.
- Latency: accept in cycle N gives out_valid=1 with the code in cycle N+1 when the output is empty or draining. Throughput is 1 per cycle while out_ready=1.
- Occupancy state machine (main register plus one skid register):
  - EMPTY: accept goes to ONE (main loaded).
  - ONE, accept & !drain: goes to FULL (skid loaded); in_ready=0 next cycle.
  - ONE, drain & !accept: goes to EMPTY.
  - ONE, accept & drain: stays ONE (main reloaded with the new code).
  - FULL: in_ready=0, so no accept. On drain, skid moves to main, state goes to ONE, in_ready=1 next cycle.
- in_ready equals the registered value of (next state != FULL).
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- out_code holds its value while out_valid & !out_ready. It must not change mid-stall.
- When out_valid=0, out_code holds its last value; do not clear it to 0.
- in_valid while in_ready=0 is ignored; the producer must hold the transfer.
- xfer_cnt increments by 1 on each drain and wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-operation (FULL, stalled): both entries are discarded, outputs go to reset values asynchronously, and xfer_cnt is cleared.
- Index range: every index is legal, so there is no undefined output.

Test Plan:
- Reset release, IN_W=2, out_ready=1; stream idx 0,1,2,3 with mode 0 on consecutive cycles -> out_code 1,2,4,8 on cycles 1..4 after accept, out_valid continuous, xfer_cnt=4.
- Mode 1, idx 0..3 -> out_code 4'b0001, 0011, 0111, 1111; in_en=0 with idx=3, mode 1 -> 4'b0000 with out_valid=1.
- out_ready=0, push idx 1 then 2 -> in_ready drops to 0 the cycle after the second accept, out_code holds 4'b0010. Raise out_ready -> 4'b0010 then 4'b0100 in order, in_ready returns to 1.
- Simultaneous accept/drain in ONE with out_ready=1 for 100 random transfers -> no bubbles, codes match the model, xfer_cnt=100.
- CNT_W=4, 17 transfers -> xfer_cnt wraps to 1.
- Assert rst_n=0 asynchronously mid-cycle while FULL -> out_valid=0, out_code=0, xfer_cnt=0, in_ready=1 immediately; the first transfer after release decodes correctly.

Source files
------------

// File: rtl/decoder_pipe_if.sv
// Handshake bundle for decoder_pipe: producer side (index in) and
// consumer side (decoded code out).
interface decoder_pipe_if #(
  parameter int IN_W = 2
) ();
  localparam int OUT_W = 1 << IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  logic             in_mode;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_code;

  // Decoder side
  modport slave (
    input  in_valid, in_idx, in_mode, in_en, out_ready,
    output in_ready, out_valid, out_code
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_idx, in_mode, in_en, out_ready,
    input  in_ready, out_valid, out_code
  );
endinterface

// File: rtl/decoder_pipe.sv
// Registered index decoder (one-hot or thermometer) with valid/ready on
// both sides and a main+skid output buffer, so that in_ready can be a
// register and still sustain one transfer per cycle.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main entry presented on out_code
// FULL  | main presented, skid holds the next entry, in_ready=0
module decoder_pipe #(
  parameter int IN_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  decoder_pipe_if.slave    bus,
  output logic [CNT_W-1:0] xfer_cnt
);
  localparam int OUT_W = 1 << IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [OUT_W-1:0] main_q, skid_q, dec_code;
  logic             rdy_q;
  logic             accept, drain;
  logic             load_main, load_skid, main_from_skid;

  assign accept        = bus.in_valid & rdy_q;
  assign drain         = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_code  = main_q;

  // Combinational decode of the incoming index; disabled decode gives zeros
  always_comb begin
    dec_code = '0;
    if (bus.in_en) begin
      for (int i = 0; i < OUT_W; i++) begin
        dec_code[i] = bus.in_mode ? (i <= int'(bus.in_idx)) : (i == int'(bus.in_idx));
      end
    end
  end

  // Occupancy next-state and buffer load controls
  always_comb begin
    state_nxt      = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen
        if (drain) begin
          state_nxt      = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register and registered in_ready (low exactly when FULL next)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      rdy_q   <= (state_nxt != FULL);
    end
  end

  // Main and skid data registers; main holds its value when idle or stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec_code;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_code;
      end
    end
  end

  // Completed output transfer counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (drain) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
endmodule
